// File: rtl/rename_tag_freelist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rename_pkg
//  Description : Shared constants, tag type and helpers for the rename
//                free-tag allocator.
//  Revision    : 1.0 - initial release
// ============================================================================
package rename_pkg;

    localparam int PTAG_W   = 6;          // physical tag width
    localparam int NUM_ARCH = 32;         // architectural registers (identity tags)
    localparam int NUM_TAGS = 32;         // renameable tags held in the pool
    localparam int TAG_BASE = NUM_ARCH;   // first renameable tag

    typedef logic [PTAG_W-1:0] ptag_t;

    // Number of asserted enables out of two (0..2).
    function automatic logic [1:0] popcount2(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/rename_tag_freelist_tag_ring.sv
`default_nettype none
// ============================================================================
//  Module      : tag_ring
//  Description : Generic 2-read / 2-write circular buffer of tags with
//                head (read/allocate) and tail (write/release) pointers and
//                a free-entry count. Reset and reload both restore the
//                initial contents ring[i] = BASE + i with the ring full.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_reload        - synchronous reload to initial contents
//                i_alloc_n       - entries consumed at head (0..2)
//                i_rel_n         - entries written at tail (0..2)
//                i_wdata0/1      - data written at tail, tail+1
//                o_rdata0/1      - ring[head], ring[head+1]
//                o_count         - number of valid entries
//  Revision    : 1.0 - initial release
// ============================================================================
module tag_ring #(
    parameter int W     = 6,
    parameter int DEPTH = 32,   // must be a power of two
    parameter int BASE  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_reload,
    input  logic [1:0]               i_alloc_n,
    input  logic [1:0]               i_rel_n,
    input  logic [W-1:0]             i_wdata0,
    input  logic [W-1:0]             i_wdata1,
    output logic [W-1:0]             o_rdata0,
    output logic [W-1:0]             o_rdata1,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                c_aw      = $clog2(DEPTH);
    localparam logic [c_aw-1:0]   c_one_idx = 1;
    localparam logic [c_aw:0]     c_full    = (c_aw+1)'(DEPTH);
    // Tail starts one full lap ahead of head: wrap bits differ -> ring full.
    localparam logic [c_aw:0]     c_tail0   = {1'b1, {c_aw{1'b0}}};

    logic [W-1:0]    r_ring [DEPTH];
    logic [c_aw:0]   r_head;
    logic [c_aw:0]   r_tail;
    logic [c_aw:0]   r_count;

    logic [c_aw-1:0] w_head_idx;
    logic [c_aw-1:0] w_head_idx1;
    logic [c_aw-1:0] w_tail_idx;
    logic [c_aw-1:0] w_tail_idx1;
    logic [c_aw:0]   w_alloc_x;
    logic [c_aw:0]   w_rel_x;

    // Index arithmetic drops the wrap bit, so +1 wraps DEPTH-1 -> 0.
    assign w_head_idx  = r_head[c_aw-1:0];
    assign w_head_idx1 = w_head_idx + c_one_idx;
    assign w_tail_idx  = r_tail[c_aw-1:0];
    assign w_tail_idx1 = w_tail_idx + c_one_idx;
    assign w_alloc_x   = {{(c_aw-1){1'b0}}, i_alloc_n};
    assign w_rel_x     = {{(c_aw-1){1'b0}}, i_rel_n};

    assign o_rdata0 = r_ring[w_head_idx];
    assign o_rdata1 = r_ring[w_head_idx1];
    assign o_count  = r_count;

    always_ff @(posedge clk) begin
        if (rst || i_reload) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ring[i] <= W'(BASE + i);
            end
            r_head  <= '0;
            r_tail  <= c_tail0;
            r_count <= c_full;
        end else begin
            if (i_rel_n != 2'd0) begin
                r_ring[w_tail_idx] <= i_wdata0;
            end
            if (i_rel_n == 2'd2) begin
                r_ring[w_tail_idx1] <= i_wdata1;
            end
            r_head  <= r_head + w_alloc_x;
            r_tail  <= r_tail + w_rel_x;
            r_count <= r_count - w_alloc_x + w_rel_x;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rename_tag_freelist.sv
`default_nettype none
// ============================================================================
//  Module      : rename_tag_freelist
//  Description : Free physical-tag allocator for the dual-issue rename
//                table. Offers up to two destination tags per cycle with
//                zero latency, stalls rename when too few tags are free,
//                takes tags back on commit and reloads on recover.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                recover               - flush; pool returns to reset state
//                stall_ext             - downstream stall, blocks allocation
//                rd1_en/rd2_en         - slot needs a destination tag
//                rd1p/rd2p             - offered tags
//                stall_RNR             - rename stall
//                rel1_en/rel2_en       - commit slot frees a tag
//                rel1p/rel2p           - tags freed by commit
//                free_cnt              - registered free-tag count
//                ovf_err               - sticky bad-release flag
//  Revision    : 1.0 - initial release
// ============================================================================
module rename_tag_freelist #(
    parameter int PTAG_W   = rename_pkg::PTAG_W,
    parameter int NUM_TAGS = rename_pkg::NUM_TAGS,
    parameter int TAG_BASE = rename_pkg::TAG_BASE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              recover,
    input  logic              stall_ext,
    input  logic              rd1_en,
    input  logic              rd2_en,
    output logic [PTAG_W-1:0] rd1p,
    output logic [PTAG_W-1:0] rd2p,
    output logic              stall_RNR,
    input  logic              rel1_en,
    input  logic              rel2_en,
    input  logic [PTAG_W-1:0] rel1p,
    input  logic [PTAG_W-1:0] rel2p,
    output logic [PTAG_W-1:0] free_cnt,
    output logic              ovf_err
);

    import rename_pkg::*;

    localparam int                c_cw    = $clog2(NUM_TAGS) + 1;
    localparam logic [c_cw:0]     c_cap   = (c_cw+1)'(NUM_TAGS);
    localparam logic [PTAG_W-1:0] c_base  = PTAG_W'(TAG_BASE);
    localparam logic [PTAG_W-1:0] c_base1 = PTAG_W'(TAG_BASE + 1);

    logic [PTAG_W-1:0] w_rd0;
    logic [PTAG_W-1:0] w_rd1;
    logic [c_cw-1:0]   w_count;
    logic [1:0]        w_need;
    logic              w_short;
    logic              w_fire;
    logic [1:0]        w_alloc_n;
    logic [c_cw:0]     w_room;
    logic              w_act;
    logic              w_rel1_ok;
    logic              w_rel2_ok;
    logic              w_rel_err;
    logic [1:0]        w_rel_n;
    logic [PTAG_W-1:0] w_wdata0;
    logic              r_ovf;

    // All-or-nothing: a pair that does not fit is stalled as a whole.
    assign w_need    = popcount2(rd1_en, rd2_en);
    assign w_short   = {{(c_cw-2){1'b0}}, w_need} > w_count;
    assign stall_RNR = !rst & (recover | w_short);
    assign w_fire    = !rst & !recover & !w_short & !stall_ext & (w_need != 2'd0);
    assign w_alloc_n = w_fire ? w_need : 2'd0;

    // Capacity left after this cycle's allocation. Releases are judged in
    // slot order against it; one that would overfill the pool or names an
    // architectural tag is dropped and flagged.
    assign w_room    = c_cap - ({1'b0, w_count} - {{(c_cw-1){1'b0}}, w_alloc_n});
    assign w_act     = !rst & !recover;
    assign w_rel1_ok = w_act & rel1_en & (rel1p >= c_base) & (w_room != '0);
    assign w_rel2_ok = w_act & rel2_en & (rel2p >= c_base)
                       & (w_room > {{c_cw{1'b0}}, w_rel1_ok});
    assign w_rel_err = w_act & ((rel1_en & !w_rel1_ok) | (rel2_en & !w_rel2_ok));
    assign w_rel_n   = popcount2(w_rel1_ok, w_rel2_ok);
    // Accepted releases are packed: a lone slot-2 tag goes to tail.
    assign w_wdata0  = w_rel1_ok ? rel1p : rel2p;

    tag_ring #(
        .W     (PTAG_W),
        .DEPTH (NUM_TAGS),
        .BASE  (TAG_BASE)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .i_reload  (recover),
        .i_alloc_n (w_alloc_n),
        .i_rel_n   (w_rel_n),
        .i_wdata0  (w_wdata0),
        .i_wdata1  (rel2p),
        .o_rdata0  (w_rd0),
        .o_rdata1  (w_rd1),
        .o_count   (w_count)
    );

    // During the reset cycle the ring registers are not yet initialised,
    // so the post-reset head values are presented directly.
    assign rd1p = rst ? c_base  : w_rd0;
    assign rd2p = rst ? c_base1 : ((rd1_en & rd2_en) ? w_rd1 : w_rd0);

    assign free_cnt = PTAG_W'(w_count);
    assign ovf_err  = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_rel_err) begin
            r_ovf <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rename_tag_freelist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rename_tag_freelist
//  Description : Self-checking bench for rename_tag_freelist: directed
//                vector table, hand sequences and randomized traffic checked
//                against a queue-based free-list model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rename_tag_freelist;

    logic       clk;
    logic       rst, recover, stall_ext;
    logic       rd1_en, rd2_en, rel1_en, rel2_en;
    logic [5:0] rel1p, rel2p;
    logic [5:0] rd1p, rd2p, free_cnt;
    logic       stall_RNR, ovf_err;

    rename_tag_freelist dut (
        .clk       (clk),
        .rst       (rst),
        .recover   (recover),
        .stall_ext (stall_ext),
        .rd1_en    (rd1_en),
        .rd2_en    (rd2_en),
        .rd1p      (rd1p),
        .rd2p      (rd2p),
        .stall_RNR (stall_RNR),
        .rel1_en   (rel1_en),
        .rel2_en   (rel2_en),
        .rel1p     (rel1p),
        .rel2p     (rel2p),
        .free_cnt  (free_cnt),
        .ovf_err   (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: FIFO of free tags, list of tags handed out.
    int fq[$];
    int inuse[$];
    bit m_ovf  = 1'b0;
    bit m_init = 1'b0;

    typedef struct {
        bit       r, rc, se, e1, e2, l1, l2;
        int       p1, p2;
        bit [1:0] cr;   // bit0: check rd1p, bit1: check rd2p
        bit       cc;   // check free_cnt / ovf_err
        bit       xs;
        int       x1, x2, xc;
        bit       xo;
    } vec_t;

    vec_t tv[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void reset_model();
        fq.delete();
        for (int i = 0; i < 32; i++) fq.push_back(32 + i);
        inuse.delete();
    endfunction

    function automatic void release_tag(input int t);
        if (t < 32 || fq.size() >= 32) m_ovf = 1'b1;
        else fq.push_back(t);
    endfunction

    // Drive one cycle of inputs and check the combinational outputs
    // against the model's current state.
    task automatic apply(input bit r, input bit rc, input bit se, input bit a1, input bit a2,
                         input bit q1, input bit q2, input int p1, input int p2);
        int need;
        bit xs;
        rst = r; recover = rc; stall_ext = se;
        rd1_en = a1; rd2_en = a2; rel1_en = q1; rel2_en = q2;
        rel1p = p1[5:0]; rel2p = p2[5:0];
        #1;
        if (r) begin
            chk("stall_rst", {31'd0, stall_RNR}, 0);
            chk("rd1p_rst", {26'd0, rd1p}, 32);
            chk("rd2p_rst", {26'd0, rd2p}, 33);
        end else begin
            need = int'(a1) + int'(a2);
            xs = rc || (need > fq.size());
            chk("stall", {31'd0, stall_RNR}, {31'd0, xs});
            if (!xs && a1) chk("rd1p", {26'd0, rd1p}, fq[0]);
            if (!xs && a2) chk("rd2p", {26'd0, rd2p}, fq[a1 ? 1 : 0]);
            if (m_init) begin
                chk("free_cnt", {26'd0, free_cnt}, fq.size());
                chk("ovf_err", {31'd0, ovf_err}, {31'd0, m_ovf});
            end
        end
    endtask

    // Advance one clock and apply the specification rules to the model.
    task automatic tick();
        int need;
        @(posedge clk);
        if (rst) begin
            reset_model();
            m_ovf  = 1'b0;
            m_init = 1'b1;
        end else if (recover) begin
            reset_model();
        end else begin
            need = int'(rd1_en) + int'(rd2_en);
            if (need <= fq.size() && !stall_ext && need > 0)
                for (int k = 0; k < need; k++) inuse.push_back(fq.pop_front());
            if (rel1_en) release_tag(int'(rel1p));
            if (rel2_en) release_tag(int'(rel2p));
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit r, rc, se, a1, a2, q1, q2;
        int p1, p2, idx;

        //            r  rc se e1 e2 l1 l2 p1  p2  cr cc xs x1  x2  xc  xo
        tv[0]  = '{1, 0, 0, 1, 1, 0, 0, 0,  0,  3, 0, 0, 32, 33, 0,  0};
        tv[1]  = '{0, 0, 0, 1, 1, 0, 0, 0,  0,  3, 1, 0, 32, 33, 32, 0};
        tv[2]  = '{0, 0, 0, 1, 1, 0, 0, 0,  0,  3, 1, 0, 34, 35, 30, 0};
        tv[3]  = '{0, 0, 0, 0, 1, 0, 0, 0,  0,  2, 1, 0, 0,  36, 28, 0};
        tv[4]  = '{0, 0, 1, 1, 0, 0, 0, 0,  0,  1, 1, 0, 37, 0,  27, 0};
        tv[5]  = '{0, 0, 0, 1, 0, 0, 0, 0,  0,  1, 1, 0, 37, 0,  27, 0};
        tv[6]  = '{0, 0, 0, 0, 0, 1, 0, 5,  0,  0, 1, 0, 0,  0,  26, 0};
        tv[7]  = '{0, 0, 0, 0, 0, 0, 0, 0,  0,  0, 1, 0, 0,  0,  26, 1};
        tv[8]  = '{0, 1, 0, 1, 0, 1, 0, 40, 0,  0, 1, 1, 0,  0,  26, 1};
        tv[9]  = '{0, 0, 0, 1, 0, 0, 0, 0,  0,  1, 1, 0, 32, 0,  32, 1};
        tv[10] = '{0, 0, 0, 0, 0, 1, 0, 32, 0,  0, 1, 0, 0,  0,  31, 1};
        tv[11] = '{1, 0, 0, 0, 0, 0, 0, 0,  0,  3, 0, 0, 32, 33, 0,  0};
        tv[12] = '{0, 0, 0, 0, 0, 1, 0, 45, 0,  0, 1, 0, 0,  0,  32, 0};
        tv[13] = '{0, 0, 0, 1, 1, 0, 0, 0,  0,  3, 1, 0, 32, 33, 32, 1};
        tv[14] = '{0, 0, 0, 1, 1, 1, 1, 32, 33, 3, 1, 0, 34, 35, 30, 1};

        rst = 1'b1; recover = 1'b0; stall_ext = 1'b0;
        rd1_en = 1'b0; rd2_en = 1'b0; rel1_en = 1'b0; rel2_en = 1'b0;
        rel1p = '0; rel2p = '0;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 15; i++) begin
            apply(tv[i].r, tv[i].rc, tv[i].se, tv[i].e1, tv[i].e2,
                  tv[i].l1, tv[i].l2, tv[i].p1, tv[i].p2);
            chk($sformatf("tv%0d_stall", i), {31'd0, stall_RNR}, {31'd0, tv[i].xs});
            if (tv[i].cr[0]) chk($sformatf("tv%0d_rd1p", i), {26'd0, rd1p}, tv[i].x1);
            if (tv[i].cr[1]) chk($sformatf("tv%0d_rd2p", i), {26'd0, rd2p}, tv[i].x2);
            if (tv[i].cc) begin
                chk($sformatf("tv%0d_cnt", i), {26'd0, free_cnt}, tv[i].xc);
                chk($sformatf("tv%0d_ovf", i), {31'd0, ovf_err}, {31'd0, tv[i].xo});
            end
            tick();
        end

        // Exhaust the pool, stall on empty, no same-cycle bypass, refill.
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 16; i++) begin
            apply(0, 0, 0, 1, 1, 0, 0, 0, 0); tick();
        end
        apply(0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("empty_stall", {31'd0, stall_RNR}, 1);
        chk("empty_cnt", {26'd0, free_cnt}, 0);
        tick();
        apply(0, 0, 0, 1, 0, 1, 0, 40, 0);
        chk("nobypass_stall", {31'd0, stall_RNR}, 1);
        tick();
        apply(0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("refill_stall", {31'd0, stall_RNR}, 0);
        chk("refill_rd1p", {26'd0, rd1p}, 40);
        tick();
        // One free tag: a pair stalls, a single goes through.
        apply(0, 0, 0, 0, 0, 1, 0, 41, 0); tick();
        apply(0, 0, 0, 1, 1, 0, 0, 0, 0);
        chk("pair_stall", {31'd0, stall_RNR}, 1);
        chk("pair_cnt", {26'd0, free_cnt}, 1);
        tick();
        apply(0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("single_rd1p", {26'd0, rd1p}, 41);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("single_cnt", {26'd0, free_cnt}, 0);
        tick();

        // Randomized traffic against the model
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        for (int c = 0; c < 3000; c++) begin
            r  = ($urandom_range(0, 199) == 0);
            rc = ($urandom_range(0, 39) == 0);
            se = ($urandom_range(0, 5) == 0);
            a1 = ($urandom_range(0, 3) != 0);
            a2 = ($urandom_range(0, 3) != 0);
            q1 = 1'b0; q2 = 1'b0; p1 = 0; p2 = 0;
            if (inuse.size() > 0 && $urandom_range(0, 2) != 0) begin
                idx = $urandom_range(0, inuse.size() - 1);
                p1 = inuse[idx]; inuse.delete(idx); q1 = 1'b1;
            end
            if (inuse.size() > 0 && $urandom_range(0, 2) != 0) begin
                idx = $urandom_range(0, inuse.size() - 1);
                p2 = inuse[idx]; inuse.delete(idx); q2 = 1'b1;
            end
            if (!q1 && $urandom_range(0, 63) == 0) begin
                q1 = 1'b1; p1 = $urandom_range(0, 31);
            end
            apply(r, rc, se, a1, a2, q1, q2, p1, p2);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rename_tag_freelist.md
Name: rename_tag_freelist

Overview:
Free-tag allocator and controller for the dual-issue speculative rename table. It supplies the destination physical tags rd1p/rd2p that the rename table writes in the RNR stage. It generates the rename stall when too few tags are free, and returns tags to the pool when instructions commit. On recover it restores the pool to the post-reset state, matching the rename table's return to identity mapping.

Parameters:
PTAG_W, 6, physical tag width (matches rename table rd1p/rd2p width)
NUM_TAGS, 32, number of renameable tags held in the pool
TAG_BASE, 32, first renameable tag; tags 0..31 are the architectural identity mappings and are never in the pool

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
recover  in  1  flush/recover; restores the pool to reset contents
stall_ext  in  1  downstream stall (ROB/IQ full); blocks allocation
rd1_en  in  1  slot-1 instruction needs a destination tag (decoder deasserts for $0)
rd2_en  in  1  slot-2 instruction needs a destination tag
rd1p  out  PTAG_W  tag for slot 1
rd2p  out  PTAG_W  tag for slot 2
stall_RNR  out  1  rename stall to the rename table and front end
rel1_en  in  1  commit slot 1 frees a tag
rel2_en  in  1  commit slot 2 frees a tag
rel1p  in  PTAG_W  tag freed by commit slot 1 (the superseded mapping)
rel2p  in  PTAG_W  tag freed by commit slot 2
free_cnt  out  PTAG_W  number of tags currently free (0..NUM_TAGS)
ovf_err  out  1  sticky error flag; set on release beyond capacity or release of a tag below TAG_BASE

Behaviour:
- Storage: a circular ring of NUM_TAGS entries of PTAG_W bits.
- Pointers: head (allocate) and tail (release), each log2(NUM_TAGS)+1 bits. The MSB is the wrap bit. count = free entries.
- Reset (sync, rst=1): ring[i] = TAG_BASE+i; head=0, tail=0, wrap bits differ (full); count=NUM_TAGS; ovf_err=0.
- Output values in the reset cycle: rd1p=TAG_BASE, rd2p=TAG_BASE+1, stall_RNR=0.
- need = rd1_en + rd2_en (0..2).
- Tag assignment is combinational from registered state, with zero latency, so the rename table writes in the same cycle:
  - rd1_en=1: rd1p = ring[head]; rd2p = ring[head+1] if rd2_en.
  - rd1_en=0, rd2_en=1: rd2p = ring[head].
  - Unused outputs drive ring[head] and are don't-care.
- stall_RNR = recover | (need > count). The condition is all-or-nothing: a pair is never partially allocated.
- Allocate fire = !rst & !recover & !stall_RNR & !stall_ext & need>0. On fire, head += need, modulo ring with wrap.
- Release: on rel*_en with !rst & !recover, write rel1p then rel2p at tail, tail, tail+1 in slot order, and advance tail by the release count.
  - If only rel2_en is set, rel2p goes to tail.
  - Released tags are allocatable from the next cycle; there is no same-cycle bypass.
- Simultaneous alloc and release: count_next = count - alloc + rel. The full case (count=NUM_TAGS) with release is an error. The empty case with alloc is blocked by stall_RNR.
- Error: if count - alloc + rel > NUM_TAGS, or a released tag < TAG_BASE, set ovf_err (sticky until rst). The offending release is dropped and count is unchanged by it.
- Recover: highest priority after rst. In the same cycle, alloc and release are ignored and the ring, pointers and count reload the reset contents. ovf_err is preserved. stall_RNR=1 during the recover cycle.
- Wrap-around: pointer arithmetic is modulo NUM_TAGS on the index bits, and the wrap bit toggles on crossing. Two-entry accesses that straddle the end index ring[NUM_TAGS-1] and ring[0].
- Reset or recover mid-stall simply reinitialises; no FSM state survives.
- free_cnt = count (registered).

Decomposition:
- Shared package rename_pkg:
  - PTAG_W, NUM_ARCH=32, NUM_TAGS, TAG_BASE;
  - typedef ptag_t;
  - function popcount2 (two enables to 0..2).
- One sub-module is natural: tag_ring, a generic 2-read/2-write circular buffer with head/tail/count and a synchronous reload input.
- rename_tag_freelist adds the stall, priority and error logic around it.

Test Plan:
- Reset, then rd1_en=rd2_en=1 for one cycle -> rd1p=32, rd2p=33, stall_RNR=0; next cycle free_cnt=30 and head offers 34,35.
- Allocate pairs for 16 cycles until free_cnt=0, then rd1_en=1 -> stall_RNR=1 and count stays 0. Release rel1p=40 -> next cycle stall_RNR=0 and rd1p=40.
- With free_cnt=1, set rd1_en=rd2_en=1 -> stall_RNR=1, no allocation, free_cnt stays 1. Drop rd2_en -> rd1p issued, free_cnt=0.
- Same cycle: allocate 2 and release 2 (tags 32,33) with free_cnt=5 -> free_cnt stays 5. After wrap the ring yields 32,33 in FIFO order, including across the index 31->0 boundary.
- After 10 allocations assert recover together with rd1_en and rel1_en -> stall_RNR=1; next cycle free_cnt=32, rd1p=32, and the release is ignored.
- At free_cnt=32 assert rel1_en with rel1p=45, or rel1p=5 at any time -> ovf_err=1 (sticky), count unchanged; rst clears ovf_err.
